// File: rtl/cmos_pkg.sv
// Shared definitions for the DVP capture front end and the splicing stage.
// Holds the capture FSM state type, the default frame geometry and the
// width of the line/pixel counters, plus a saturating-increment helper.
package cmos_pkg;

    typedef enum logic {
        SKIP   = 1'b0,
        ACTIVE = 1'b1
    } cap_state_t;

    localparam int unsigned CNT_W         = 11;
    localparam int unsigned CMOS_H_ACTIVE = 640;
    localparam int unsigned CMOS_V_ACTIVE = 480;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Counter increment that sticks at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cmos_edge_det.sv
// Registered rise/fall detector.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   sig   - input level (already registered by the caller)
//   sig_d - sig delayed one cycle; rise/fall are aligned with this copy
//   rise  - high for the first cycle sig_d is high
//   fall  - high for the first cycle sig_d is low
module cmos_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic sig_d,
    output logic rise,
    output logic fall
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_d <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sig_d <= sig;
            rise  <= sig & ~sig_d;
            fall  <= ~sig & sig_d;
        end
    end

endmodule

// File: rtl/cmos_capture_8to16.sv
// OV5640 DVP capture: drops start-up frames, packs byte pairs into RGB565
// pixels, re-times vsync/href to the packed data and checks frame geometry.
// Ports:
//   cmos_pclk     - sensor pixel clock, sole clock
//   sys_rst       - synchronous active-high reset
//   cmos_vsync_in - raw vsync, high between frames
//   cmos_href_in  - raw href, high during active line bytes
//   cmos_data_in  - raw byte, high byte of each pixel first
//   cmos_vsync    - vsync delayed 2 cycles, gated by frame_valid
//   cmos_href     - href delayed 2 cycles, gated by frame_valid
//   cmos_de       - one-cycle strobe, cmos_data holds a new pixel
//   cmos_data     - packed pixel {high byte, low byte}
//   frame_valid   - high once the start-up frames have been skipped
//   line_cnt      - completed lines in the current frame (saturating)
//   pix_cnt       - pixels emitted in the current line (saturating)
//   size_err      - sticky frame geometry error
module cmos_capture_8to16
    import cmos_pkg::*;
#(
    parameter int unsigned FRAME_SKIP = 10,
    parameter int unsigned H_ACTIVE   = CMOS_H_ACTIVE,
    parameter int unsigned V_ACTIVE   = CMOS_V_ACTIVE
) (
    input  logic             cmos_pclk,
    input  logic             sys_rst,
    input  logic             cmos_vsync_in,
    input  logic             cmos_href_in,
    input  logic [7:0]       cmos_data_in,
    output logic             cmos_vsync,
    output logic             cmos_href,
    output logic             cmos_de,
    output logic [15:0]      cmos_data,
    output logic             frame_valid,
    output logic [CNT_W-1:0] line_cnt,
    output logic [CNT_W-1:0] pix_cnt,
    output logic             size_err
);

    localparam int unsigned SKIP_W = (FRAME_SKIP == 0) ? 1 : $clog2(FRAME_SKIP + 1);

    cap_state_t        state;
    logic [SKIP_W-1:0] skip_cnt;

    logic       vs_q1, hr_q1;
    logic [7:0] d_q1, d_q2;
    logic       vs_q2, vs_rise, vs_fall_unused;
    logic       hr_q2, hr_rise, hr_fall;
    logic       phase;
    logic [7:0] hi_byte;

    // Edge detectors also provide the second pipeline stage for vsync/href.
    cmos_edge_det u_vs_edge (
        .clk  (cmos_pclk),
        .rst  (sys_rst),
        .sig  (vs_q1),
        .sig_d(vs_q2),
        .rise (vs_rise),
        .fall (vs_fall_unused)
    );

    cmos_edge_det u_hr_edge (
        .clk  (cmos_pclk),
        .rst  (sys_rst),
        .sig  (hr_q1),
        .sig_d(hr_q2),
        .rise (hr_rise),
        .fall (hr_fall)
    );

    // Capture FSM, byte pairing, counters and geometry check.
    always_ff @(posedge cmos_pclk) begin
        if (sys_rst) begin
            state       <= SKIP;
            skip_cnt    <= '0;
            vs_q1       <= 1'b0;
            hr_q1       <= 1'b0;
            d_q1        <= '0;
            d_q2        <= '0;
            phase       <= 1'b0;
            hi_byte     <= '0;
            cmos_vsync  <= 1'b0;
            cmos_href   <= 1'b0;
            cmos_de     <= 1'b0;
            cmos_data   <= '0;
            frame_valid <= 1'b0;
            line_cnt    <= '0;
            pix_cnt     <= '0;
            size_err    <= 1'b0;
        end else begin
            vs_q1      <= cmos_vsync_in;
            hr_q1      <= cmos_href_in;
            d_q1       <= cmos_data_in;
            d_q2       <= d_q1;
            cmos_de    <= 1'b0;
            cmos_vsync <= vs_q2 & frame_valid;
            cmos_href  <= hr_q2 & frame_valid;

            // Leave SKIP on the rising edge that ends the last skipped frame.
            case (state)
                SKIP: begin
                    if (vs_rise) begin
                        if (skip_cnt == SKIP_W'(FRAME_SKIP)) begin
                            state       <= ACTIVE;
                            frame_valid <= 1'b1;
                        end else begin
                            skip_cnt <= skip_cnt + SKIP_W'(1);
                        end
                    end
                end
                ACTIVE: begin
                end
                default: begin
                    state <= SKIP;
                end
            endcase

            // Phase 0 holds the high byte; phase 1 emits the pixel.
            if (hr_q2) begin
                phase <= ~phase;
                if (!phase) begin
                    hi_byte <= d_q2;
                end else if (state == ACTIVE) begin
                    cmos_data <= {hi_byte, d_q2};
                    cmos_de   <= 1'b1;
                end
            end else begin
                phase <= 1'b0;
            end

            if (hr_rise) begin
                pix_cnt <= '0;
            end else if (hr_q2 && phase && (state == ACTIVE)) begin
                pix_cnt <= sat_inc(pix_cnt);
            end

            // vsync clears first so a coincident line start sees a fresh frame.
            if (vs_rise) begin
                line_cnt <= '0;
            end else if (hr_fall) begin
                line_cnt <= sat_inc(line_cnt);
            end

            // phase still set at href fall means the line had an odd byte count.
            if (state == ACTIVE) begin
                if (hr_fall && ((pix_cnt != CNT_W'(H_ACTIVE)) || phase)) begin
                    size_err <= 1'b1;
                end
                if (vs_rise && (line_cnt != CNT_W'(V_ACTIVE))) begin
                    size_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmos_capture_8to16.sv
// Bench for cmos_capture_8to16: two instances (FRAME_SKIP=2 and 0) share one
// randomized sensor stream; a frame/line level model predicts pixels,
// frame_valid, counters and size_err.
module tb_cmos_capture_8to16;

    localparam int H      = 8;
    localparam int V      = 4;
    localparam int SKIP_A = 2;
    localparam int SKIP_B = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync_in = 1'b0;
    logic        href_in = 1'b0;
    logic [7:0]  data_in = 8'h00;

    logic        vs_a, hr_a, de_a, fv_a, err_a;
    logic [15:0] data_a;
    logic [10:0] lc_a, pc_a;
    logic        vs_b, hr_b, de_b, fv_b, err_b;
    logic [15:0] data_b;
    logic [10:0] lc_b, pc_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: vsync rises since reset, lines since last vsync, sticky error.
    int          k[2];
    int          lines[2];
    bit          err_m[2];
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    always #5 clk = ~clk;

    cmos_capture_8to16 #(.FRAME_SKIP(SKIP_A), .H_ACTIVE(H), .V_ACTIVE(V)) dut_a (
        .cmos_pclk(clk), .sys_rst(rst), .cmos_vsync_in(vsync_in),
        .cmos_href_in(href_in), .cmos_data_in(data_in),
        .cmos_vsync(vs_a), .cmos_href(hr_a), .cmos_de(de_a), .cmos_data(data_a),
        .frame_valid(fv_a), .line_cnt(lc_a), .pix_cnt(pc_a), .size_err(err_a)
    );

    cmos_capture_8to16 #(.FRAME_SKIP(SKIP_B), .H_ACTIVE(H), .V_ACTIVE(V)) dut_b (
        .cmos_pclk(clk), .sys_rst(rst), .cmos_vsync_in(vsync_in),
        .cmos_href_in(href_in), .cmos_data_in(data_in),
        .cmos_vsync(vs_b), .cmos_href(hr_b), .cmos_de(de_b), .cmos_data(data_b),
        .frame_valid(fv_b), .line_cnt(lc_b), .pix_cnt(pc_b), .size_err(err_b)
    );

    function automatic bit act(int i);
        return k[i] >= ((i == 0) ? SKIP_A : SKIP_B) + 1;
    endfunction

    function automatic int sat(int v);
        return (v > 2047) ? 2047 : v;
    endfunction

    // Scoreboard: every pixel strobe must match the next predicted pixel.
    always @(negedge clk) begin
        if (de_a) begin
            n_checks++;
            if (exp_a.size() == 0) begin
                n_fail++;
                $display("FAIL pixel_a unexpected de got=%h exp=none", data_a);
            end else if (data_a !== exp_a[0]) begin
                n_fail++;
                $display("FAIL pixel_a got=%h exp=%h", data_a, exp_a[0]);
                void'(exp_a.pop_front());
            end else begin
                void'(exp_a.pop_front());
            end
        end
        if (de_b) begin
            n_checks++;
            if (exp_b.size() == 0) begin
                n_fail++;
                $display("FAIL pixel_b unexpected de got=%h exp=none", data_b);
            end else if (data_b !== exp_b[0]) begin
                n_fail++;
                $display("FAIL pixel_b got=%h exp=%h", data_b, exp_b[0]);
                void'(exp_b.pop_front());
            end else begin
                void'(exp_b.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vsync_in = 1'b0;
            href_in  = 1'b0;
            data_in  = 8'h00;
        end
    endtask

    task automatic vsync_pulse();
        bit old_v[2];
        bit new_v[2];
        for (int i = 0; i < 2; i++) begin
            old_v[i] = act(i);
            if (old_v[i] && lines[i] != V) err_m[i] = 1'b1;
            k[i]++;
            lines[i] = 0;
            new_v[i] = act(i);
        end
        @(negedge clk); vsync_in = 1'b1; href_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks += 2;
        if (fv_a !== old_v[0]) begin n_fail++; $display("FAIL fv_a_before got=%b exp=%b", fv_a, old_v[0]); end
        if (fv_b !== old_v[1]) begin n_fail++; $display("FAIL fv_b_before got=%b exp=%b", fv_b, old_v[1]); end
        @(negedge clk); vsync_in = 1'b0;
        n_checks += 4;
        if (fv_a !== new_v[0]) begin n_fail++; $display("FAIL fv_a_after got=%b exp=%b", fv_a, new_v[0]); end
        if (fv_b !== new_v[1]) begin n_fail++; $display("FAIL fv_b_after got=%b exp=%b", fv_b, new_v[1]); end
        if (vs_a !== old_v[0]) begin n_fail++; $display("FAIL vsync_a_first got=%b exp=%b", vs_a, old_v[0]); end
        if (vs_b !== old_v[1]) begin n_fail++; $display("FAIL vsync_b_first got=%b exp=%b", vs_b, old_v[1]); end
        @(negedge clk);
        n_checks += 2;
        if (vs_a !== new_v[0]) begin n_fail++; $display("FAIL vsync_a_second got=%b exp=%b", vs_a, new_v[0]); end
        if (vs_b !== new_v[1]) begin n_fail++; $display("FAIL vsync_b_second got=%b exp=%b", vs_b, new_v[1]); end
        idle(4);
        n_checks += 4;
        if (lc_a !== 11'd0) begin n_fail++; $display("FAIL line_cnt_a_clear got=%0d exp=0", lc_a); end
        if (lc_b !== 11'd0) begin n_fail++; $display("FAIL line_cnt_b_clear got=%0d exp=0", lc_b); end
        if (err_a !== err_m[0]) begin n_fail++; $display("FAIL size_err_a_vs got=%b exp=%b", err_a, err_m[0]); end
        if (err_b !== err_m[1]) begin n_fail++; $display("FAIL size_err_b_vs got=%b exp=%b", err_b, err_m[1]); end
    endtask

    // mode 0: random line; 1: starts with F8,1F and checks its latency;
    // 2: one-cycle reset while the third byte is presented.
    task automatic send_line(input int nbytes, input int mode);
        logic [7:0] b;
        logic [7:0] hi;
        bit a0, a1;
        int pc_exp;
        hi = 8'h00;
        if (mode == 2) begin
            for (int i = 0; i < 2; i++) begin
                k[i] = 0; lines[i] = 0; err_m[i] = 1'b0;
            end
        end
        a0 = act(0);
        a1 = act(1);
        for (int j = 0; j < nbytes; j++) begin
            @(negedge clk);
            if (mode == 1 && j == 3) begin
                n_checks += 2;
                if (de_a !== 1'b0) begin n_fail++; $display("FAIL de_a_early got=%b exp=0", de_a); end
                if (de_b !== 1'b0) begin n_fail++; $display("FAIL de_b_early got=%b exp=0", de_b); end
            end
            if (mode == 1 && j == 4) begin
                n_checks += 2;
                if ({de_a, data_a} !== {1'b1, 16'hF81F}) begin
                    n_fail++; $display("FAIL pair_a got de=%b data=%h exp de=1 data=f81f", de_a, data_a);
                end
                if ({de_b, data_b} !== {1'b1, 16'hF81F}) begin
                    n_fail++; $display("FAIL pair_b got de=%b data=%h exp de=1 data=f81f", de_b, data_b);
                end
            end
            if (mode == 2 && j == 3) begin
                n_checks += 2;
                if ({vs_a, hr_a, de_a, data_a, fv_a, lc_a, pc_a, err_a} !== 43'd0) begin
                    n_fail++; $display("FAIL midline_reset_a got=%h exp=0", {vs_a, hr_a, de_a, data_a, fv_a, lc_a, pc_a, err_a});
                end
                if ({vs_b, hr_b, de_b, data_b, fv_b, lc_b, pc_b, err_b} !== 43'd0) begin
                    n_fail++; $display("FAIL midline_reset_b got=%h exp=0", {vs_b, hr_b, de_b, data_b, fv_b, lc_b, pc_b, err_b});
                end
            end
            b = 8'($urandom);
            if (mode == 1 && j == 0) b = 8'hF8;
            if (mode == 1 && j == 1) b = 8'h1F;
            vsync_in = 1'b0;
            href_in  = 1'b1;
            data_in  = b;
            rst      = (mode == 2 && j == 2);
            if (j % 2 == 0) begin
                hi = b;
            end else begin
                if (a0) exp_a.push_back({hi, b});
                if (a1) exp_b.push_back({hi, b});
            end
        end
        rst = 1'b0;
        idle(6);
        if (a0 && nbytes != 2 * H) err_m[0] = 1'b1;
        if (a1 && nbytes != 2 * H) err_m[1] = 1'b1;
        lines[0]++;
        lines[1]++;
        pc_exp = sat(nbytes / 2);
        n_checks += 8;
        if (lc_a !== 11'(sat(lines[0]))) begin n_fail++; $display("FAIL line_cnt_a got=%0d exp=%0d", lc_a, sat(lines[0])); end
        if (lc_b !== 11'(sat(lines[1]))) begin n_fail++; $display("FAIL line_cnt_b got=%0d exp=%0d", lc_b, sat(lines[1])); end
        if (pc_a !== (a0 ? 11'(pc_exp) : 11'd0)) begin n_fail++; $display("FAIL pix_cnt_a got=%0d exp=%0d", pc_a, a0 ? pc_exp : 0); end
        if (pc_b !== (a1 ? 11'(pc_exp) : 11'd0)) begin n_fail++; $display("FAIL pix_cnt_b got=%0d exp=%0d", pc_b, a1 ? pc_exp : 0); end
        if (exp_a.size() != 0) begin n_fail++; $display("FAIL missing_pixels_a got=%0d exp=0", exp_a.size()); exp_a.delete(); end
        if (exp_b.size() != 0) begin n_fail++; $display("FAIL missing_pixels_b got=%0d exp=0", exp_b.size()); exp_b.delete(); end
        if (err_a !== err_m[0]) begin n_fail++; $display("FAIL size_err_a_line got=%b exp=%b", err_a, err_m[0]); end
        if (err_b !== err_m[1]) begin n_fail++; $display("FAIL size_err_b_line got=%b exp=%b", err_b, err_m[1]); end
    endtask

    task automatic send_frame(input int nlines, input int odd_line);
        vsync_pulse();
        for (int l = 0; l < nlines; l++) send_line((l == odd_line) ? 2 * H + 1 : 2 * H, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_checks += 2;
        if ({vs_a, hr_a, de_a, data_a, fv_a, lc_a, pc_a, err_a} !== 43'd0) begin
            n_fail++; $display("FAIL reset_a got=%h exp=0", {vs_a, hr_a, de_a, data_a, fv_a, lc_a, pc_a, err_a});
        end
        if ({vs_b, hr_b, de_b, data_b, fv_b, lc_b, pc_b, err_b} !== 43'd0) begin
            n_fail++; $display("FAIL reset_b got=%h exp=0", {vs_b, hr_b, de_b, data_b, fv_b, lc_b, pc_b, err_b});
        end
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; lines[i] = 0; err_m[i] = 1'b0;
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_skip_frames();
        send_line(2 * H, 0);
        send_line(2 * H, 0);
        for (int f = 0; f < 4; f++) send_frame(V, -1);
        n_checks += 2;
        if (fv_a !== 1'b1) begin n_fail++; $display("FAIL skip_fv_a got=%b exp=1", fv_a); end
        if (err_a !== 1'b0) begin n_fail++; $display("FAIL skip_err_a got=%b exp=0", err_a); end
    endtask

    task automatic test_pixel_pair();
        vsync_pulse();
        send_line(2 * H, 1);
        for (int l = 1; l < V; l++) send_line(2 * H, 0);
    endtask

    task automatic test_reset_mid_line();
        send_line(2 * H, 2);
        n_checks += 2;
        if (fv_a !== 1'b0) begin n_fail++; $display("FAIL rst_fv_a got=%b exp=0", fv_a); end
        if (fv_b !== 1'b0) begin n_fail++; $display("FAIL rst_fv_b got=%b exp=0", fv_b); end
    endtask

    task automatic test_short_frame();
        send_frame(V - 1, -1);
        vsync_pulse();
        n_checks += 2;
        if (err_a !== 1'b0) begin n_fail++; $display("FAIL short_skip_err_a got=%b exp=0", err_a); end
        if (err_b !== 1'b1) begin n_fail++; $display("FAIL short_active_err_b got=%b exp=1", err_b); end
        for (int l = 0; l < V; l++) send_line(2 * H, 0);
    endtask

    task automatic test_odd_line();
        send_frame(V, -1);
        n_checks++;
        if (err_a !== 1'b0) begin n_fail++; $display("FAIL odd_pre_err_a got=%b exp=0", err_a); end
        send_frame(V, 0);
        send_frame(V, -1);
        vsync_pulse();
        n_checks++;
        if (err_a !== 1'b1) begin n_fail++; $display("FAIL odd_sticky_err_a got=%b exp=1", err_a); end
    endtask

    task automatic test_saturation();
        send_line(4100, 0);
        n_checks++;
        if (pc_a !== 11'd2047) begin n_fail++; $display("FAIL pix_cnt_sat_a got=%0d exp=2047", pc_a); end
    endtask

    initial begin
        test_reset();
        test_skip_frames();
        test_pixel_pair();
        test_reset_mid_line();
        test_short_frame();
        test_odd_line();
        test_saturation();
        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmos_capture_8to16.md
# cmos_capture_8to16

Per-camera DVP capture front end: takes the OV5640 8-bit pixel bus, drops the start-up frames the sensor emits while its AEC/AWB settle, and packs byte pairs into 16-bit RGB565 pixels. It also re-times vsync/href to match the packed data. One instance sits in front of each camera (cmos0, cmos1), feeding the dual-camera splicing stage. Frame geometry is checked against the expected size and flagged on mismatch.

## Interface
Parameters:
- FRAME_SKIP, 10, number of complete frames discarded after reset (0 allowed)
- H_ACTIVE, 640, expected pixels (16-bit) per line
- V_ACTIVE, 480, expected lines per frame

Ports:
- cmos_pclk  in  1  sensor pixel clock; sole clock of the block
- sys_rst  in  1  reset; synchronous to cmos_pclk, active-high
- cmos_vsync_in  in  1  raw sensor vsync, high between frames
- cmos_href_in  in  1  raw sensor href, high during active line bytes
- cmos_data_in  in  8  raw sensor byte, high byte of each pixel first
- cmos_vsync  out  1  vsync, delayed 2 cycles, gated by frame_valid
- cmos_href  out  1  href, delayed 2 cycles, gated by frame_valid
- cmos_de  out  1  one-cycle strobe: cmos_data holds a new pixel
- cmos_data  out  16  packed pixel {high byte, low byte}
- frame_valid  out  1  high once skipping is finished (state ACTIVE)
- line_cnt  out  11  completed lines in the current frame
- pix_cnt  out  11  pixels emitted in the current line
- size_err  out  1  sticky geometry error

## Operation
- Stage 1: all three sensor inputs are registered once; edge detection runs on the registered vsync and href.
- FSM states:
  - SKIP (reset state): skip_cnt counts vsync rising edges. On a rising edge, if skip_cnt == FRAME_SKIP, go to ACTIVE; otherwise increment skip_cnt.
  - ACTIVE: held until sys_rst.
  - Consequence: the partial frame in progress at reset is always dropped, plus FRAME_SKIP complete frames.
- Byte pairing: a phase bit toggles on each registered-href-high cycle and is cleared while href is low.
  - Phase 0: latch the byte into the high-byte register.
  - Phase 1: load {hi, byte} into cmos_data and pulse cmos_de, only in ACTIVE.
- Odd byte at line end: the byte is discarded and no cmos_de is issued; in ACTIVE this sets size_err.
- pix_cnt:
  - Cleared on registered href rising edge.
  - Increments with each cmos_de.
  - Saturates at 2047.
- line_cnt:
  - Cleared on vsync rising edge.
  - Increments on href falling edge.
  - Saturates at 2047.
- size_err sets (ACTIVE only; sticky until sys_rst) when any of:
  - href falls with pix_cnt != H_ACTIVE;
  - odd byte count on a line;
  - vsync rises with line_cnt != V_ACTIVE. This check is skipped on the edge that entered ACTIVE.
- cmos_data holds its last value when cmos_de is low.

## Timing
- Reset (sys_rst high at a cmos_pclk edge) forces, from the next cycle:
  - all outputs to 0;
  - skip_cnt = 0, phase = 0, FSM = SKIP.
- Reset asserted mid-frame abandons the frame and restarts the skip count.
- Pixel latency: the low byte is sampled at input edge n; cmos_de and cmos_data are valid after edge n+2.
- cmos_href and cmos_vsync use the same 2-cycle delay, so they stay aligned with cmos_de.
  - For a line of 2·H_ACTIVE bytes: cmos_href is high 2·H_ACTIVE cycles; cmos_de pulses H_ACTIVE times, every other cycle.
- FSM transition takes effect on the cycle after the registered vsync rising edge; frame_valid rises at that point.
- href rising in the same cycle as vsync rising (sensor glitch): the vsync edge is processed first, then the line starts with counters cleared.
- Downstream consumes pixels on cmos_de, not cmos_href.

## Structure
- Shared package cmos_pkg:
  - capture state enum {SKIP, ACTIVE};
  - default constants H_ACTIVE=640, V_ACTIVE=480, also used by the splicing stage;
  - counter width 11.
- One sub-module, cmos_edge_det: a registered rise/fall detector, instantiated for vsync and href.

## Test plan
- FRAME_SKIP=2, start mid-frame, send 4 frames of 640×480: no cmos_de during the partial frame or frames 1–2; frame_valid rises 1 cycle after the 3rd vsync rising edge; frame 3 yields 307200 cmos_de pulses; size_err=0.
- Byte stream 0xF8,0x1F on one line: cmos_data=0xF81F with cmos_de high exactly 2 cycles after 0x1F is sampled.
- Line with 1281 bytes in ACTIVE: 640 pixels emitted, last byte dropped, size_err=1, and it stays 1 across the following frames.
- Frame with 479 lines, followed by vsync rising: size_err=1. The same short frame in SKIP: size_err=0.
- sys_rst pulsed for 1 cycle mid-line in ACTIVE: all outputs 0 on the next cycle, FSM=SKIP, skip count restarts; no cmos_de until FRAME_SKIP+1 vsync rising edges later.
- FRAME_SKIP=0: the first vsync rising edge after reset enters ACTIVE, and the very next full frame is output.
